// File: rtl/decoder_n_to_2n_reg.sv
// decoder_n_to_2n_reg
// Registered N-to-2^N one-hot decoder. Its main job is generating write
// enables for a register file (5:32 by default, with r0 write-protected).
// It also has an optional sweep mode that asserts every enabled output in
// turn, one per cycle, so the register file can be cleared or scanned.
//
// Build option:
//   DEC_SWEEP_EN  when defined, the SWEEP state, the sweep counter, busy
//                 and sweep_done are built. When undefined, only the decoder
//                 is built: i_sweep_start is ignored and o_busy and
//                 o_sweep_done are tied low. The port list is the same in
//                 both builds.
//
// Parameters:
//   SEL_W      select width (1..6); the output width is 2**SEL_W
//   ZERO_MASK  1: output bit 0 is never asserted (hardwired-zero register)
//
// Ports:
//   i_clk          rising-edge clock
//   i_rst          synchronous reset, active-high
//   i_en           global enable; when 0, no decode is accepted and a sweep pauses
//   i_sel          index to decode
//   i_sel_valid    i_sel is valid this cycle
//   i_sweep_start  request a sweep over all enabled outputs
//   o_y            registered one-hot output, all-zero when idle
//   o_y_valid      o_y holds a valid one-hot value
//   o_busy         sweep in progress
//   o_sweep_done   one-cycle pulse that coincides with the last sweep output
//
// state   | meaning
// S_IDLE  | accepts decodes; a sweep request emits the first sweep output
// S_SWEEP | sweep in progress; r_cnt is the index to emit next

module decoder_n_to_2n_reg #(
  parameter int SEL_W     = 5,
  parameter int ZERO_MASK = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_en,
  input  logic [SEL_W-1:0]         i_sel,
  input  logic                     i_sel_valid,
  input  logic                     i_sweep_start,
  output logic [(2**SEL_W)-1:0]    o_y,
  output logic                     o_y_valid,
  output logic                     o_busy,
  output logic                     o_sweep_done
);

  localparam int OUT_W = 2**SEL_W;
  localparam logic [OUT_W-1:0] ONE = OUT_W'(1);

  logic [OUT_W-1:0] r_y;
  logic             r_y_valid;
  logic [OUT_W-1:0] w_y_nxt;
  logic             w_y_valid_nxt;
  logic             w_dec_ok;

  // A decode of index 0 is suppressed when bit 0 is masked.
  assign w_dec_ok = !((ZERO_MASK != 0) && (i_sel == '0));

`ifdef DEC_SWEEP_EN

  localparam logic [SEL_W-1:0] FIRST_IDX = (ZERO_MASK != 0) ? SEL_W'(1) : SEL_W'(0);
  localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(OUT_W - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SWEEP = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [SEL_W-1:0] r_cnt;
  logic [SEL_W-1:0] w_cnt_nxt;
  logic             r_busy;
  logic             r_sweep_done;
  logic             w_busy_nxt;
  logic             w_sweep_done_nxt;

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_y_nxt          = '0;
    w_y_valid_nxt    = 1'b0;
    w_busy_nxt       = 1'b0;
    w_sweep_done_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_en && i_sel_valid) begin
          // A decode wins over a simultaneous sweep request, and that
          // request is dropped.
          if (w_dec_ok) begin
            w_y_nxt       = ONE << i_sel;
            w_y_valid_nxt = 1'b1;
          end
        end else if (i_en && i_sweep_start) begin
          // The first sweep output is registered here so that it shows up
          // one cycle after the request. The counter then holds the next
          // index to emit.
          w_y_nxt       = ONE << FIRST_IDX;
          w_y_valid_nxt = 1'b1;
          w_busy_nxt    = 1'b1;
          if (FIRST_IDX == LAST_IDX) begin
            // This is a single-output sweep (SEL_W=1 with bit 0 masked).
            w_sweep_done_nxt = 1'b1;
          end else begin
            w_state_nxt = S_SWEEP;
            w_cnt_nxt   = FIRST_IDX + SEL_W'(1);
          end
        end
      end
      S_SWEEP: begin
        w_busy_nxt = 1'b1;
        if (i_en) begin
          w_y_nxt       = ONE << r_cnt;
          w_y_valid_nxt = 1'b1;
          if (r_cnt == LAST_IDX) begin
            w_sweep_done_nxt = 1'b1;
            w_state_nxt      = S_IDLE;
            w_cnt_nxt        = '0;
          end else begin
            w_cnt_nxt = r_cnt + SEL_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_y          <= '0;
      r_y_valid    <= 1'b0;
      r_busy       <= 1'b0;
      r_sweep_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_y          <= w_y_nxt;
      r_y_valid    <= w_y_valid_nxt;
      r_busy       <= w_busy_nxt;
      r_sweep_done <= w_sweep_done_nxt;
    end
  end

  assign o_busy       = r_busy;
  assign o_sweep_done = r_sweep_done;

`else

  logic w_unused_sweep;
  assign w_unused_sweep = i_sweep_start;

  always_comb begin
    w_y_nxt       = '0;
    w_y_valid_nxt = 1'b0;
    if (i_en && i_sel_valid && w_dec_ok) begin
      w_y_nxt       = ONE << i_sel;
      w_y_valid_nxt = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_y       <= '0;
      r_y_valid <= 1'b0;
    end else begin
      r_y       <= w_y_nxt;
      r_y_valid <= w_y_valid_nxt;
    end
  end

  assign o_busy       = 1'b0;
  assign o_sweep_done = 1'b0;

`endif

  assign o_y       = r_y;
  assign o_y_valid = r_y_valid;

endmodule

// File: tb/tb_decoder_n_to_2n_reg.sv
// Testbench for decoder_n_to_2n_reg. It drives two instances:
//   dut5: SEL_W=5, ZERO_MASK=1
//   dut2: SEL_W=2, ZERO_MASK=0
// Each stimulus cycle pushes the outputs expected one cycle later.
// A monitor pops one entry after every rising edge and compares it with
// both instances.

module tb_decoder_n_to_2n_reg;

  logic        clk;
  logic        rst;
  logic        en5, sv5, ss5;
  logic [4:0]  sel5;
  logic [31:0] y5;
  logic        yv5, busy5, done5;
  logic        en2, sv2, ss2;
  logic [1:0]  sel2;
  logic [3:0]  y2;
  logic        yv2, busy2, done2;

  typedef struct {
    logic [31:0] y;
    logic        yv;
    logic        b;
    logic        d;
    logic [3:0]  y2;
    logic        yv2;
    logic        b2;
    logic        d2;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  decoder_n_to_2n_reg #(.SEL_W(5), .ZERO_MASK(1)) dut5 (
    .i_clk(clk), .i_rst(rst), .i_en(en5), .i_sel(sel5), .i_sel_valid(sv5),
    .i_sweep_start(ss5), .o_y(y5), .o_y_valid(yv5), .o_busy(busy5),
    .o_sweep_done(done5)
  );

  decoder_n_to_2n_reg #(.SEL_W(2), .ZERO_MASK(0)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_en(en2), .i_sel(sel2), .i_sel_valid(sv2),
    .i_sweep_start(ss2), .o_y(y2), .o_y_valid(yv2), .o_busy(busy2),
    .o_sweep_done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive dut5 and keep dut2 idle.
  task automatic drive5(input logic r, input logic e, input logic sv, input logic ss,
                        input logic [4:0] s, input logic [31:0] ey, input logic eyv,
                        input logic eb, input logic ed, input string nm);
    exp_t x;
    @(negedge clk);
    rst = r; en5 = e; sv5 = sv; ss5 = ss; sel5 = s;
    en2 = 1'b0; sv2 = 1'b0; ss2 = 1'b0; sel2 = 2'd0;
    x.y = ey; x.yv = eyv; x.b = eb; x.d = ed;
    x.y2 = 4'h0; x.yv2 = 1'b0; x.b2 = 1'b0; x.d2 = 1'b0; x.nm = nm;
    q.push_back(x);
  endtask

  // Drive dut2 and keep dut5 idle.
  task automatic drive2(input logic e, input logic sv, input logic ss, input logic [1:0] s,
                        input logic [3:0] ey, input logic eyv, input logic eb,
                        input logic ed, input string nm);
    exp_t x;
    @(negedge clk);
    rst = 1'b0; en5 = 1'b0; sv5 = 1'b0; ss5 = 1'b0; sel5 = 5'd0;
    en2 = e; sv2 = sv; ss2 = ss; sel2 = s;
    x.y = 32'h0; x.yv = 1'b0; x.b = 1'b0; x.d = 1'b0;
    x.y2 = ey; x.yv2 = eyv; x.b2 = eb; x.d2 = ed; x.nm = nm;
    q.push_back(x);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        checks++;
        if (y5 !== x.y || yv5 !== x.yv || busy5 !== x.b || done5 !== x.d ||
            y2 !== x.y2 || yv2 !== x.yv2 || busy2 !== x.b2 || done2 !== x.d2) begin
          errors++;
          $display("FAIL %s: got y=%h yv=%b busy=%b done=%b y2=%h yv2=%b busy2=%b done2=%b, expected y=%h yv=%b busy=%b done=%b y2=%h yv2=%b busy2=%b done2=%b",
                   x.nm, y5, yv5, busy5, done5, y2, yv2, busy2, done2,
                   x.y, x.yv, x.b, x.d, x.y2, x.yv2, x.b2, x.d2);
        end
      end
    end
  end

  initial begin : stim
    logic [31:0] ey;
    rst = 1'b1; en5 = 1'b0; sv5 = 1'b0; ss5 = 1'b0; sel5 = 5'd0;
    en2 = 1'b0; sv2 = 1'b0; ss2 = 1'b0; sel2 = 2'd0;

    // Reset, then decode
    drive5(1, 0, 0, 0, 5'd0,  32'h0000_0000, 0, 0, 0, "reset_0");
    drive5(1, 0, 0, 0, 5'd0,  32'h0000_0000, 0, 0, 0, "reset_1");
    drive5(0, 1, 1, 0, 5'd3,  32'h0000_0008, 1, 0, 0, "dec_sel3");
    drive5(0, 1, 1, 0, 5'd31, 32'h8000_0000, 1, 0, 0, "dec_sel31");
    drive5(0, 1, 1, 0, 5'd0,  32'h0000_0000, 0, 0, 0, "dec_sel0_masked");

    // Enable gating
    drive5(0, 0, 1, 0, 5'd7,  32'h0000_0000, 0, 0, 0, "en_low_gated");
    drive5(0, 1, 1, 0, 5'd7,  32'h0000_0080, 1, 0, 0, "en_high_sel7");
    drive5(0, 1, 0, 0, 5'd0,  32'h0000_0000, 0, 0, 0, "idle_no_stale");

    // Decode beats a simultaneous sweep request
    drive5(0, 1, 1, 1, 5'd2,  32'h0000_0004, 1, 0, 0, "collide_decode");
    drive5(0, 1, 0, 0, 5'd0,  32'h0000_0000, 0, 0, 0, "collide_no_sweep");

`ifdef DEC_SWEEP_EN
    // Full sweep. The request is issued at cycle t, and a decode at t+5 is ignored.
    drive5(0, 1, 0, 1, 5'd0, 32'h0000_0002, 1, 1, 0, "sweep_first");
    for (int k = 1; k <= 30; k++) begin
      ey = 32'h1 << (k + 1);
      drive5(0, 1, (k == 5), 0, (k == 5) ? 5'd4 : 5'd0, ey, 1, 1, (k == 30), "sweep_step");
    end
    drive5(0, 1, 0, 0, 5'd0, 32'h0000_0000, 0, 0, 0, "sweep_busy_low");

    // Pause at index 10
    drive5(0, 1, 0, 1, 5'd0, 32'h0000_0002, 1, 1, 0, "pause_first");
    for (int k = 1; k <= 8; k++) begin
      ey = 32'h1 << (k + 1);
      drive5(0, 1, 0, 0, 5'd0, ey, 1, 1, 0, "pause_pre");
    end
    for (int p = 0; p < 3; p++)
      drive5(0, 0, 1, 1, 5'd6, 32'h0000_0000, 0, 1, 0, "pause_hold");
    for (int i = 10; i <= 31; i++) begin
      ey = 32'h1 << i;
      drive5(0, 1, 0, 0, 5'd0, ey, 1, 1, (i == 31), "pause_resume");
    end
    drive5(0, 1, 0, 0, 5'd0, 32'h0000_0000, 0, 0, 0, "pause_end");

    // Reset at sweep index 20
    drive5(0, 1, 0, 1, 5'd0, 32'h0000_0002, 1, 1, 0, "rstmid_first");
    for (int k = 1; k <= 18; k++) begin
      ey = 32'h1 << (k + 1);
      drive5(0, 1, 0, 0, 5'd0, ey, 1, 1, 0, "rstmid_pre");
    end
    drive5(1, 1, 0, 0, 5'd0, 32'h0000_0000, 0, 0, 0, "rstmid_reset");
    drive5(0, 1, 0, 0, 5'd0, 32'h0000_0000, 0, 0, 0, "rstmid_abandoned");
    drive5(0, 1, 0, 1, 5'd0, 32'h0000_0002, 1, 1, 0, "rstmid_restart");
    drive5(0, 1, 0, 0, 5'd0, 32'h0000_0004, 1, 1, 0, "rstmid_restart_2");
    drive5(1, 0, 0, 0, 5'd0, 32'h0000_0000, 0, 0, 0, "rstmid_reset_2");

    // SEL_W=2 with ZERO_MASK=0: the sweep covers index 0 as well
    drive2(1, 0, 1, 2'd0, 4'h1, 1, 1, 0, "w2_sweep_1");
    drive2(1, 0, 0, 2'd0, 4'h2, 1, 1, 0, "w2_sweep_2");
    drive2(1, 0, 0, 2'd0, 4'h4, 1, 1, 0, "w2_sweep_4");
    drive2(1, 0, 0, 2'd0, 4'h8, 1, 1, 1, "w2_sweep_8_done");
    drive2(1, 0, 0, 2'd0, 4'h0, 0, 0, 0, "w2_sweep_end");
`else
    // Without the sweep option, a sweep request does nothing
    drive5(0, 1, 0, 1, 5'd0, 32'h0000_0000, 0, 0, 0, "nosweep_start");
    drive5(0, 1, 0, 0, 5'd0, 32'h0000_0000, 0, 0, 0, "nosweep_idle");
    drive2(1, 0, 1, 2'd0, 4'h0, 0, 0, 0, "w2_nosweep_start");
    drive2(1, 0, 0, 2'd0, 4'h0, 0, 0, 0, "w2_nosweep_idle");
`endif

    // Index 0 is decodable when unmasked
    drive2(1, 1, 0, 2'd0, 4'h1, 1, 0, 0, "w2_dec_sel0");
    drive2(1, 1, 0, 2'd3, 4'h8, 1, 0, 0, "w2_dec_sel3");
    drive2(0, 0, 0, 2'd0, 4'h0, 0, 0, 0, "w2_idle");

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #3;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decoder_n_to_2n_reg.md
Name: decoder_n_to_2n_reg

Overview:
- Parametrised, registered N-to-2^N one-hot decoder.
- Replaces the fixed combinational 2:4 decoder in the datapath.
- Primary use: register-file write-enable generation (default 5:32, r0 write-protected).
- Adds a sequential sweep mode that walks every enabled output in turn, one per cycle, for register-file clear/scan.

Parameters:
- SEL_W, 5, select width; output width OUT_W = 2**SEL_W (localparam, not overridable).
- ZERO_MASK, 1, when 1 output bit 0 is never asserted (hardwired-zero register).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- en  input  1  global enable; when 0, no new decode is accepted and any sweep pauses.
- sel  input  SEL_W  index to decode.
- sel_valid  input  1  sel is valid this cycle.
- sweep_start  input  1  request a full sweep of all outputs.
- y  output  OUT_W  registered one-hot output (all-zero when idle).
- y_valid  output  1  y holds a valid one-hot value this cycle.
- busy  output  1  sweep in progress.
- sweep_done  output  1  one-cycle pulse coincident with the last sweep output.

Behaviour:
- All outputs are registered. Reset values: y=0, y_valid=0, busy=0, sweep_done=0, state=IDLE, sweep counter=0.
- rst has priority over everything. Asserted mid-sweep: next cycle returns to IDLE with all outputs 0; the sweep is abandoned, not resumed.
- States: IDLE, SWEEP.
- IDLE, en=1, sel_valid=1:
  - Next cycle y = 1<<sel, y_valid=1 (latency 1).
  - If ZERO_MASK=1 and sel=0: y=0, y_valid=0.
- IDLE, en=1, sel_valid=0, sweep_start=1:
  - Enter SWEEP; counter loads first index (1 if ZERO_MASK else 0).
  - First sweep output appears the next cycle.
- IDLE, sel_valid=1 and sweep_start=1 in the same cycle: the decode wins and sweep_start is dropped (not queued).
- IDLE, otherwise: y=0, y_valid=0 next cycle. Outputs never hold a stale value.
- SWEEP, en=1:
  - Each cycle y = 1<<counter, y_valid=1, busy=1; counter increments.
  - When counter = OUT_W-1: sweep_done=1 on that same output cycle, and the state returns to IDLE.
  - busy deasserts the following cycle.
- SWEEP, en=0: counter holds, y=0, y_valid=0, busy stays 1. Resumes at the held index when en returns to 1.
- SWEEP ignores sel_valid and sweep_start; these are dropped, not buffered.
- Counter width is SEL_W. Terminal compare is against OUT_W-1, so the counter never wraps through 0 within a sweep.
- Sweep length: OUT_W-1 cycles with ZERO_MASK=1, OUT_W with ZERO_MASK=0.
- y is always one-hot or zero; two bits are never set simultaneously.
- Must support SEL_W from 1 to 6. With SEL_W=1 and ZERO_MASK=1, a sweep is one cycle: y=2'b10 with sweep_done=1.

Optional Feature:
- Macro: DEC_SWEEP_EN.
- Defined: SWEEP state, counter, busy and sweep_done are implemented as above.
- Undefined:
  - No SWEEP state or counter logic is synthesised.
  - sweep_start is ignored.
  - busy and sweep_done are tied to 0.
  - Decode behaviour is identical, including the 1-cycle latency and ZERO_MASK.
  - Ports remain present so the instantiation is unchanged.

Test Plan:
- Reset/decode (SEL_W=5, ZERO_MASK=1): assert rst 2 cycles, then en=1, sel_valid=1 with sel=3, 31, 0 on consecutive cycles.
  -> y = 0x0000_0008, then 0x8000_0000, then 0x0 with y_valid=0; each appears 1 cycle after its input; before that y=0, y_valid=0.
- Enable gating: en=0, sel_valid=1, sel=7 -> y=0, y_valid=0. Then en=1 -> y=0x0000_0080 on the next cycle.
- Full sweep (DEC_SWEEP_EN, SEL_W=5, ZERO_MASK=1): pulse sweep_start at cycle t.
  -> y=0x2 at t+1, then doubles each cycle until 0x8000_0000 at t+31.
  -> sweep_done=1 only at t+31; busy=1 for t+1..t+31 and 0 at t+32.
  -> sel_valid=1 with sel=4 at t+5 has no effect.
- Pause and collision: during the sweep, drop en for 3 cycles at index 10.
  -> y=0, busy=1 while en=0; resumes with y=0x400.
  -> Separately, sel_valid=1 with sel=2 plus sweep_start in the same IDLE cycle -> y=0x4 next cycle, busy stays 0.
- Reset mid-sweep: assert rst at sweep index 20 -> next cycle y=0, y_valid=0, busy=0, sweep_done=0. A new sweep_start restarts at 0x2.
- Parameter/macro corners:
  - SEL_W=2, ZERO_MASK=0 sweep -> y = 1, 2, 4, 8, with sweep_done on 8.
  - Same configuration without DEC_SWEEP_EN: sweep_start -> busy=0, y=0.
